add_subt_arbiter: RTL and testbench
===================================

# add_subt_arbiter

Two-requester round-robin arbiter and sequencer for the shared floating-point add/subtract unit. It lets the CORDIC controller and a second client, such as the range-reduction or output sign-correction stage, time-share one adder/subtractor. It latches the winning requester's operands, drives the unit's beg/ready/ack handshake, captures the result and returns it to the owner through the same beg/ready/ack protocol the clients already use.

## Interface
- W, 32: operand/result width (IEEE-754 single).
- TIMEOUT, 64: maximum cycles spent in WAIT before the transaction is aborted; 0 disables the watchdog.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs are cleared.
- beg_req0 / beg_req1  in  1  level request from client 0 / 1.
- data_a0, data_b0 / data_a1, data_b1  in  W  operands; must be stable while beg_reqN is high.
- op0 / op1  in  1  0 = add, 1 = subtract.
- ack_req0 / ack_req1  in  1  client has taken its result.
- ready_req0 / ready_req1  out  1  result valid for client 0 / 1.
- result0 / result1  out  W  per-client result register.
- beg_add_subt  out  1  start pulse to the unit.
- ack_add_subt  out  1  result-taken pulse to the unit.
- add_a, add_b  out  W  operands to the unit.
- add_op  out  1  operation to the unit.
- ready_add_subt  in  1  unit result valid.
- add_result  in  W  unit result.
- grant  out  1  index of the current or last owner.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK, DELIVER. All handshake outputs are Moore-decoded from the state register.
- **IDLE**
  - If any beg_reqN is high: select the winner, latch its data_a/data_b/op into the operand registers, set grant to the winner, go to ISSUE.
  - If both requests are high, the winner is the requester ≠ last_grant.
  - last_grant resets to 1, so client 0 wins the first tie.
- **ISSUE**: beg_add_subt = 1 for exactly this one cycle. Go to WAIT and clear the watchdog counter.
- **WAIT**
  - ready_add_subt = 1: load add_result into result[grant], go to ACK.
  - Otherwise the counter increments. If TIMEOUT ≠ 0 and the counter reaches TIMEOUT−1, set err_timeout and go to ACK; result[grant] is not updated.
- **ACK**: ack_add_subt = 1 for one cycle, then go to DELIVER.
- **DELIVER**
  - ready_req[grant] = 1 and is held until ack_req[grant] = 1.
  - On that ack: update last_grant to grant, go to IDLE.
- add_a/add_b/add_op come from the operand registers and are stable from ISSUE through ACK.
- A client must drop beg_reqN no later than the cycle it asserts ack_reqN. A beg_reqN still high in IDLE is treated as a new request.
- Ignored inputs:
  - ack_reqN outside DELIVER, or from the non-granted client.
  - ready_add_subt outside WAIT.
  - beg_reqN outside IDLE; the request is held pending by the client.
- err_timeout is cleared only by reset.
- result0/result1 hold their value until overwritten by that client's next completed transaction.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: ready_req0/1, result0/1, beg_add_subt, ack_add_subt, add_a, add_b, add_op, grant, busy, err_timeout.
  - Operand registers 0; last_grant = 1; watchdog counter 0.
- Cycle t: beg_reqN sampled high in IDLE.
- t+1: ISSUE, beg_add_subt = 1.
- t+2 onward: WAIT.
- Cycle k: ready_add_subt sampled high. k+1: ACK, with result[grant] already registered. k+2: DELIVER, ready_reqN = 1.
- Minimum request-to-ready latency: ready at t+2 gives ready_reqN at t+4.
- Cycle m: ack_reqN sampled. m+1: IDLE. The earliest next ISSUE is m+2.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. A pending unit operation is abandoned and no ack is sent.

## Test plan
- **Single request**: beg_req0 = 1 with a = 0x3F800000, b = 0x40000000, op = 0; unit ready 3 cycles after beg_add_subt with 0x40400000.
  - Required: result0 = 0x40400000, ready_req0 at t+6, exactly one beg and one ack pulse, grant = 0.
- **Simultaneous requests after reset**: both requests raised together.
  - Required: client 0 served first, then client 1 without deassertion; beg_add_subt issued at m+2 after client 0's ack.
- **Round-robin**: both requests held high for 4 transactions.
  - Required: grant sequence 0, 1, 0, 1; result0 and result1 each match their own operands.
- **Watchdog**: TIMEOUT = 8 and ready_add_subt never asserted.
  - Required: err_timeout = 1 after 8 WAIT cycles, one ack pulse, ready_req0 = 1, result0 unchanged.
- **Spurious inputs**: ready_add_subt pulsed in IDLE; ack_req1 pulsed while client 0 is in DELIVER.
  - Required: no state change; ready_req0 stays high until ack_req0.
- **Mid-operation reset**: reset asserted during WAIT.
  - Required: busy = 0 and all outputs 0 in the same cycle; the next request is granted to client 0.

Source files
------------

// File: rtl/add_subt_arbiter.sv
// ---------------------------------------------------------------------------
// add_subt_arbiter
// Round-robin arbiter/sequencer that lets two clients time-share one
// floating-point add/subtract unit. The winner's operands are latched, the
// unit is driven through its beg/ready/ack handshake, and the result is
// returned to the owner through the same beg/ready/ack protocol.
//
// Ports
//   clk, reset             : clock (rising edge), async active-high reset
//   beg_req0/1             : level request from client 0/1
//   data_a0/b0, data_a1/b1 : client operands, op0/op1 : 0 add, 1 subtract
//   ack_req0/1             : client has taken its result
//   ready_req0/1           : result valid for client 0/1
//   result0/1              : per-client result registers
//   beg_add_subt           : start pulse to the unit
//   ack_add_subt           : result-taken pulse to the unit
//   add_a, add_b, add_op   : operands / operation to the unit
//   ready_add_subt         : unit result valid
//   add_result             : unit result
//   grant                  : current or last owner
//   busy                   : high in every state except IDLE
//   err_timeout            : sticky watchdog flag
// ---------------------------------------------------------------------------
module add_subt_arbiter #(
   parameter int W       = 32,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         beg_req0,
   input  logic         beg_req1,
   input  logic [W-1:0] data_a0,
   input  logic [W-1:0] data_b0,
   input  logic [W-1:0] data_a1,
   input  logic [W-1:0] data_b1,
   input  logic         op0,
   input  logic         op1,
   input  logic         ack_req0,
   input  logic         ack_req1,
   output logic         ready_req0,
   output logic         ready_req1,
   output logic [W-1:0] result0,
   output logic [W-1:0] result1,
   output logic         beg_add_subt,
   output logic         ack_add_subt,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   output logic         add_op,
   input  logic         ready_add_subt,
   input  logic [W-1:0] add_result,
   output logic         grant,
   output logic         busy,
   output logic         err_timeout
);

   // Counter only has to reach TIMEOUT-1; it wraps harmlessly when the
   // watchdog is disabled.
   localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] C_TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_DELIVER
   } state_t;

   state_t        r_state, w_next;
   logic [W-1:0]  r_a, r_b, r_res0, r_res1;
   logic          r_op, r_grant, r_last_grant, r_err;
   logic [CW-1:0] r_cnt;

   logic w_any, w_win, w_ack_g, w_tmo;

   assign w_any   = beg_req0 | beg_req1;
   // On a tie the client that did not own the unit last time wins; a lone
   // request simply wins.
   assign w_win   = (beg_req0 & beg_req1) ? ~r_last_grant : beg_req1;
   // Only the owner's ack counts; the other client's ack is ignored.
   assign w_ack_g = r_grant ? ack_req1 : ack_req0;
   assign w_tmo   = (TIMEOUT != 0) && (r_cnt == C_TMAX);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_any) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_WAIT;
         S_WAIT:    if (ready_add_subt || w_tmo) w_next = S_ACK;
         S_ACK:     w_next = S_DELIVER;
         S_DELIVER: if (w_ack_g) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= 1'b0;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_err        <= 1'b0;
         r_cnt        <= '0;
         r_res0       <= '0;
         r_res1       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_win;
                  r_a     <= w_win ? data_a1 : data_a0;
                  r_b     <= w_win ? data_b1 : data_b0;
                  r_op    <= w_win ? op1 : op0;
               end
            end
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (ready_add_subt) begin
                  if (r_grant) r_res1 <= add_result;
                  else         r_res0 <= add_result;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  // abort path: result register deliberately left alone
                  if (w_tmo) r_err <= 1'b1;
               end
            end
            S_DELIVER: if (w_ack_g) r_last_grant <= r_grant;
            default: ;
         endcase
      end
   end

   // Moore outputs
   assign beg_add_subt = (r_state == S_ISSUE);
   assign ack_add_subt = (r_state == S_ACK);
   assign ready_req0   = (r_state == S_DELIVER) && !r_grant;
   assign ready_req1   = (r_state == S_DELIVER) &&  r_grant;
   assign busy         = (r_state != S_IDLE);
   assign add_a        = r_a;
   assign add_b        = r_b;
   assign add_op       = r_op;
   assign grant        = r_grant;
   assign result0      = r_res0;
   assign result1      = r_res1;
   assign err_timeout  = r_err;

endmodule

// File: tb/tb_add_subt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_subt_arbiter
// Directed bench for add_subt_arbiter with a small behavioural model of the
// add/subtract unit (fixed latency, optional "never answers").
// ---------------------------------------------------------------------------
module tb_add_subt_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        beg_req0 = 0, beg_req1 = 0, op0 = 0, op1 = 0;
   logic        ack_req0 = 0, ack_req1 = 0;
   logic [31:0] data_a0 = 0, data_b0 = 0, data_a1 = 0, data_b1 = 0;
   logic        ready_req0, ready_req1, beg_add_subt, ack_add_subt, add_op;
   logic [31:0] result0, result1, add_a, add_b, add_result;
   logic        ready_add_subt, grant, busy, err_timeout;

   // unit model
   int          unit_lat = 3;       // 0 = never answers
   bit          use_fix  = 1'b0;
   logic [31:0] fixval   = 32'h0;
   int          u_cnt    = 0;
   logic        u_ready  = 1'b0;
   logic        spur_rdy = 1'b0;
   logic [31:0] u_res    = 32'h0;

   int n_chk = 0, n_err = 0;
   int n_beg = 0, n_ack = 0;

   assign ready_add_subt = u_ready | spur_rdy;
   assign add_result     = u_res;

   always #5 clk = ~clk;

   add_subt_arbiter #(.W(32), .TIMEOUT(8)) dut (
      .clk(clk), .reset(rst),
      .beg_req0(beg_req0), .beg_req1(beg_req1),
      .data_a0(data_a0), .data_b0(data_b0),
      .data_a1(data_a1), .data_b1(data_b1),
      .op0(op0), .op1(op1),
      .ack_req0(ack_req0), .ack_req1(ack_req1),
      .ready_req0(ready_req0), .ready_req1(ready_req1),
      .result0(result0), .result1(result1),
      .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
      .add_a(add_a), .add_b(add_b), .add_op(add_op),
      .ready_add_subt(ready_add_subt), .add_result(add_result),
      .grant(grant), .busy(busy), .err_timeout(err_timeout)
   );

   // unit answers unit_lat cycles after the cycle beg_add_subt is high
   always @(posedge clk) begin
      u_ready <= 1'b0;
      if (beg_add_subt && unit_lat != 0) begin
         u_cnt <= unit_lat - 1;
         u_res <= use_fix ? fixval : (add_op ? add_a - add_b : add_a + add_b);
      end else if (u_cnt > 1) begin
         u_cnt <= u_cnt - 1;
      end else if (u_cnt == 1) begin
         u_ready <= 1'b1;
         u_cnt   <= 0;
      end
   end

   always @(posedge clk) begin
      if (beg_add_subt) n_beg <= n_beg + 1;
      if (ack_add_subt) n_ack <= n_ack + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // bounded wait for a DELIVER state; expiry is a failed comparison
   task automatic wait_dlv(input string tag);
      int k;
      k = 0;
      while (!(ready_req0 || ready_req1) && k < 30) begin
         tick();
         k++;
      end
      chk(tag, {31'b0, ready_req0 | ready_req1}, 32'd1);
   endtask

   int b0, a0;
   logic [31:0] exp_g;

   initial begin
      // ---------------- reset state
      tick(); tick();
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_grant", {31'b0, grant}, 0);
      chk("rst_res0", result0, 0);
      chk("rst_adda", add_a, 0);
      chk("rst_outs", {26'b0, ready_req0, ready_req1, beg_add_subt,
                       ack_add_subt, add_op, err_timeout}, 0);
      rst = 1'b0;
      tick();

      // ---------------- single request: ready 3 cycles after beg
      unit_lat = 3; use_fix = 1; fixval = 32'h40400000;
      data_a0 = 32'h3F800000; data_b0 = 32'h40000000; op0 = 0; beg_req0 = 1;
      tick();                                   // t+1
      chk("s_beg", {31'b0, beg_add_subt}, 1);
      chk("s_grant", {31'b0, grant}, 0);
      chk("s_adda", add_a, 32'h3F800000);
      chk("s_addb", add_b, 32'h40000000);
      beg_req0 = 0;
      tick(); tick(); tick(); tick();           // t+5
      chk("s_ack", {31'b0, ack_add_subt}, 1);
      chk("s_rdy_early", {31'b0, ready_req0}, 0);
      tick();                                   // t+6
      chk("s_rdy", {31'b0, ready_req0}, 1);
      chk("s_res0", result0, 32'h40400000);
      chk("s_nbeg", n_beg, 1);
      chk("s_nack", n_ack, 1);
      ack_req0 = 1;
      tick();
      ack_req0 = 0;
      chk("s_idle", {31'b0, busy}, 0);
      chk("s_rdy_drop", {31'b0, ready_req0}, 0);

      // ---------------- simultaneous requests after reset
      rst = 1; tick(); rst = 0; tick();
      unit_lat = 2; use_fix = 0;
      data_a0 = 32'd1;  data_b0 = 32'd2; op0 = 0;
      data_a1 = 32'd10; data_b1 = 32'd3; op1 = 1;
      beg_req0 = 1; beg_req1 = 1;
      tick();
      chk("t_grant0", {31'b0, grant}, 0);
      tick(); tick(); tick(); tick();           // DELIVER
      chk("t_rdy0", {31'b0, ready_req0}, 1);
      chk("t_res0", result0, 32'd3);
      beg_req0 = 0; ack_req0 = 1;
      tick();                                   // m+1
      ack_req0 = 0;
      chk("t_idle", {31'b0, busy}, 0);
      tick();                                   // m+2
      chk("t_beg_m2", {31'b0, beg_add_subt}, 1);
      chk("t_grant1", {31'b0, grant}, 1);
      tick(); tick(); tick(); tick();
      chk("t_rdy1", {31'b0, ready_req1}, 1);
      chk("t_res1", result1, 32'd7);
      beg_req1 = 0; ack_req1 = 1;
      tick();
      ack_req1 = 0;
      chk("t_res0_hold", result0, 32'd3);

      // ---------------- round-robin, both held for 4 transactions
      unit_lat = 3;
      data_a0 = 32'h100; data_b0 = 32'h23;  op0 = 0;
      data_a1 = 32'h500; data_b1 = 32'h100; op1 = 1;
      beg_req0 = 1; beg_req1 = 1;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 32'd0 : 32'd1;
         wait_dlv("rr_wait");
         chk("rr_grant", {31'b0, grant}, exp_g);
         if (exp_g == 0) chk("rr_res0", result0, 32'h123);
         else            chk("rr_res1", result1, 32'h400);
         if (i == 3) begin beg_req0 = 0; beg_req1 = 0; end
         if (grant) ack_req1 = 1; else ack_req0 = 1;
         tick();
         ack_req0 = 0; ack_req1 = 0;
      end

      // ---------------- watchdog (TIMEOUT = 8, unit never answers)
      unit_lat = 0;
      b0 = n_beg; a0 = n_ack;
      data_a0 = 32'hDEAD; data_b0 = 32'hBEEF;
      beg_req0 = 1;
      tick();                                   // ISSUE
      beg_req0 = 0;
      for (int i = 0; i < 8; i++) tick();       // t+9: 8th WAIT cycle
      chk("w_err_early", {31'b0, err_timeout}, 0);
      chk("w_busy", {31'b0, busy}, 1);
      tick();                                   // ACK
      chk("w_err", {31'b0, err_timeout}, 1);
      chk("w_ackp", {31'b0, ack_add_subt}, 1);
      tick();                                   // DELIVER
      chk("w_rdy", {31'b0, ready_req0}, 1);
      chk("w_res0", result0, 32'h123);
      chk("w_nack", n_ack - a0, 1);
      chk("w_nbeg", n_beg - b0, 1);

      // ---------------- spurious inputs
      ack_req1 = 1;
      tick();
      ack_req1 = 0;
      chk("sp_rdy_hold", {31'b0, ready_req0}, 1);
      tick();
      chk("sp_rdy_hold2", {31'b0, ready_req0}, 1);
      ack_req0 = 1;
      tick();
      ack_req0 = 0;
      chk("sp_idle", {31'b0, busy}, 0);
      spur_rdy = 1;
      tick();
      spur_rdy = 0;
      chk("sp_busy", {31'b0, busy}, 0);
      chk("sp_beg", {31'b0, beg_add_subt}, 0);
      chk("sp_res0", result0, 32'h123);
      chk("sp_err", {31'b0, err_timeout}, 1);

      // ---------------- mid-operation reset
      unit_lat = 3;
      beg_req1 = 1;
      tick(); tick();                           // WAIT
      beg_req1 = 0;
      chk("r_busy_pre", {31'b0, busy}, 1);
      #2 rst = 1;
      #1;
      chk("r_busy", {31'b0, busy}, 0);
      chk("r_grant", {31'b0, grant}, 0);
      chk("r_res1", result1, 0);
      chk("r_adda", add_a, 0);
      chk("r_outs", {26'b0, ready_req0, ready_req1, beg_add_subt,
                     ack_add_subt, add_op, err_timeout}, 0);
      tick(); tick(); tick(); tick();
      rst = 0;
      beg_req0 = 1; beg_req1 = 1;
      tick();
      chk("r_next_beg", {31'b0, beg_add_subt}, 1);
      chk("r_next_grant", {31'b0, grant}, 0);
      beg_req0 = 0; beg_req1 = 0;
      wait_dlv("r_wait");
      chk("r_next_rdy0", {31'b0, ready_req0}, 1);
      ack_req0 = 1;
      tick();
      ack_req0 = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
